dm_access_ctrl: RTL and testbench
=================================

DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for mem_ack before bus error.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  pipeline presents a load/store.
REQ-005 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-006 SHALL have port req_size  in  2  0 = word, 1 = half, 2 = byte, 3 = treated as word.
REQ-007 SHALL have port req_sext  in  1  load extension: 1 = sign, 0 = zero.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL have port req_ready  out  1  controller idle and able to accept.
REQ-011 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  out  32  extended load result.
REQ-013 SHALL have port resp_exc  out  2  0 = none, 1 = misaligned load, 2 = misaligned store, 3 = bus timeout.
REQ-014 SHALL have port stall  out  1  freeze upstream pipeline.
REQ-015 SHALL have port mem_req  out  1  memory request, held until ack.
REQ-016 SHALL have port mem_we  out  1  memory write enable.
REQ-017 SHALL have port mem_addr  out  32  word address, bits [1:0] = 0.
REQ-018 SHALL have port mem_be  out  4  byte enables.
REQ-019 SHALL have port mem_wdata  out  32  lane-aligned store data.
REQ-020 SHALL have port mem_ack  in  1  memory completion, one-cycle pulse.
REQ-021 SHALL have port mem_rdata  in  32  read word, valid when mem_ack = 1.

Function
REQ-022 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-023 SHALL assert req_ready only in IDLE; accept on req_valid & req_ready, latching we, size, sext, addr and wdata.
REQ-024 SHALL detect misalignment at acceptance: half with addr[0] = 1, or word with addr[1:0] != 0.
REQ-025 On an aligned accept, SHALL go IDLE -> ACCESS and drive mem_req = 1 starting the next cycle.
REQ-026 On a misaligned accept, SHALL go IDLE -> RESP with resp_exc = 1 (load) or 2 (store), and SHALL NOT assert mem_req.
REQ-027 In ACCESS, SHALL hold mem_req, mem_we, mem_addr, mem_be and mem_wdata stable until mem_ack.
REQ-028 On mem_ack in ACCESS, SHALL register the extracted and extended load data and go to RESP.
REQ-029 In RESP, SHALL assert resp_valid for exactly one cycle, then return to IDLE.
REQ-030 Latency: accept at cycle N, ack at cycle M >= N+1, resp_valid at M+1; zero-wait memory gives resp_valid at N+2.
REQ-031 mem_be SHALL be 4'b1111 for word; 4'b0011 << (2*addr[1]) for half; 4'b0001 << addr[1:0] for byte.
REQ-032 mem_wdata SHALL be: word unchanged; half replicated {wdata[15:0], wdata[15:0]}; byte replicated x4.
REQ-033 Load extraction SHALL take half = mem_rdata[16*addr[1] +: 16] and byte = mem_rdata[8*addr[1:0] +: 8], then zero- or sign-extend to 32 per req_sext; a word load passes through unchanged.
REQ-034 resp_rdata SHALL be 0 for stores and for any nonzero resp_exc.
REQ-035 SHALL run an 8-bit wait counter in ACCESS, cleared on entry; when it reaches TIMEOUT without mem_ack, SHALL drop mem_req and go to RESP with resp_exc = 3.
REQ-036 A mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL win (normal completion, resp_exc = 0).
REQ-037 mem_ack outside ACCESS SHALL be ignored.
REQ-038 stall SHALL equal (req_valid & IDLE) | ACCESS | (RESP & ~resp_valid); it is 0 in the resp_valid cycle.
REQ-039 In IDLE, mem_req SHALL be 0, and mem_be and mem_we SHALL be 0.

Reset
REQ-040 While reset = 0, SHALL asynchronously force IDLE, counter = 0, and all outputs 0 except req_ready = 1.
REQ-041 Reset asserted in ACCESS SHALL abandon the transaction: mem_req drops immediately and no resp_valid is produced.
REQ-042 After reset deasserts, SHALL accept a new request on the first rising edge.

Verification
REQ-043 SHALL test: lbu addr 0x1003, mem_rdata 0x80FF1234, ack after 3 cycles -> mem_be 0000 during request, mem_addr 0x1000, resp_rdata 0x00000080 four cycles after accept.
REQ-044 SHALL test: lh addr 0x2002, mem_rdata 0x8001FFFF, ack after 0 cycles -> resp_rdata 0xFFFF8001 at N+2.
REQ-045 SHALL test: sb addr 0x3001, wdata 0x000000AB -> mem_be 0010, mem_wdata 0xABABABAB, mem_we 1, resp_rdata 0.
REQ-046 SHALL test: sw addr 0x4002 -> no mem_req, resp_valid at N+1 with resp_exc 2.
REQ-047 SHALL test: TIMEOUT = 4, no ack -> mem_req drops after 4 cycles, resp_exc 3; a repeat run with ack in cycle 4 -> resp_exc 0.
REQ-048 SHALL test: reset pulled low mid-ACCESS -> mem_req 0 at once, req_ready 1, no resp_valid; back-to-back requests after release complete in order.

Source files
------------

// File: rtl/dm_access_ctrl_if.sv
// Bundles the pipeline-side load/store handshake and the memory-side request/ack port of dm_access_ctrl.
// Request transfers on the rising edge where req_valid & req_ready; mem_req stays high with stable fields until the mem_ack pulse.
interface dm_access_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_exc;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_exc, stall,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_exc, stall,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: aligns stores into byte lanes, extracts/extends loads,
// flags misalignment up front and bounds each memory access with a wait-cycle timeout.
module dm_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  dm_access_ctrl_if.slave  bus,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  exc_q, exc_d;

  logic        in_idle, in_access, in_resp;
  logic [1:0]  size_norm;
  logic        misaligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [15:0] half_c;
  logic [7:0]  byte_c;
  logic [31:0] load_c;

  assign in_idle   = (state_q == IDLE);
  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  // Size 3 is folded into word at acceptance so downstream logic sees only 0/1/2.
  assign size_norm  = (bus.req_size == 2'd3) ? 2'd0 : bus.req_size;
  assign misaligned = ((size_norm == 2'd1) && bus.req_addr[0]) ||
                      ((size_norm == 2'd0) && (bus.req_addr[1:0] != 2'b00));

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata_q;
    case (size_q)
      2'd1: begin
        be_c    = 4'b0011 << {addr_q[1], 1'b0};
        wdata_c = {2{wdata_q[15:0]}};
      end
      2'd2: begin
        be_c    = 4'b0001 << addr_q[1:0];
        wdata_c = {4{wdata_q[7:0]}};
      end
      default: ;
    endcase
  end

  assign half_c = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  assign byte_c = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];

  always_comb begin
    load_c = bus.mem_rdata;
    case (size_q)
      2'd1:    load_c = sext_q ? {{16{half_c[15]}}, half_c} : {16'h0000, half_c};
      2'd2:    load_c = sext_q ? {{24{byte_c[7]}}, byte_c} : {24'h000000, byte_c};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = size_norm;
          sext_d  = bus.req_sext;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rdata_d = 32'h0;
          cnt_d   = 8'h00;
          if (misaligned) begin
            exc_d   = bus.req_we ? 2'd2 : 2'd1;
            state_d = RESP;
          end else begin
            exc_d   = 2'd0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // An ack in the final allowed cycle still completes normally.
        if (bus.mem_ack) begin
          rdata_d = we_q ? 32'h0 : load_c;
          state_d = RESP;
        end else if (cnt_q == TMO_LAST) begin
          exc_d   = 2'd3;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'h00;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      sext_q  <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      exc_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
    end
  end

  // Byte enables and write data qualify stores only; a load drives an all-zero mask.
  assign bus.req_ready  = in_idle;
  assign bus.resp_valid = in_resp;
  assign bus.resp_rdata = in_resp ? rdata_q : 32'h0;
  assign bus.resp_exc   = in_resp ? exc_q : 2'd0;
  assign bus.stall      = (bus.req_valid & in_idle) | in_access | (in_resp & ~bus.resp_valid);
  assign bus.mem_req    = in_access;
  assign bus.mem_we     = in_access & we_q;
  assign bus.mem_addr   = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_be     = (in_access & we_q) ? be_c : 4'b0000;
  assign bus.mem_wdata  = (in_access & we_q) ? wdata_c : 32'h0;
  assign state_o        = state_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: a memory responder with programmable ack delay,
// a response monitor popping a scoreboard queue, and hand-computed expectations.
module tb_dm_access_ctrl;
  localparam int TMO = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  state_o;
  logic        ack_r;
  logic        stray_ack;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  dm_access_ctrl_if bus();
  assign bus.mem_ack = ack_r | stray_ack;

  dm_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o)
  );

  // Clock and cycle count
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: {exc, rdata} and the negedge cycle at which resp_valid is due
  logic [33:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [33:0] mon_e;
  int          mon_c;

  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid with rdata 0x%0h exc %0d expected none",
                 bus.resp_rdata, bus.resp_exc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("resp_rdata", bus.resp_rdata, mon_e[31:0]);
        check("resp_exc", bus.resp_exc, mon_e[33:32]);
        check("resp_cycle", cyc, mon_c);
        check("stall_in_resp", bus.stall, 1'b0);
      end
    end
  end

  // Memory responder: acks in the (ack_at+1)-th cycle of mem_req; ack_at < 0 never acks
  int          ack_at = -1;
  int          k = 0;
  int          req_cycles = 0;
  bit          saw_req = 0;
  logic [31:0] rd_word = 32'h0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  always @(negedge clk) begin
    ack_r = 1'b0;
    bus.mem_rdata = rd_word;
    if (bus.mem_req === 1'b1) begin
      if (k == 0) begin
        cap_addr  = bus.mem_addr;
        cap_wdata = bus.mem_wdata;
        cap_be    = bus.mem_be;
        cap_we    = bus.mem_we;
        saw_req   = 1'b1;
      end else begin
        check("mem_hold_ctrl", {bus.mem_we, bus.mem_be, bus.mem_addr}, {cap_we, cap_be, cap_addr});
        check("mem_hold_wdata", bus.mem_wdata, cap_wdata);
      end
      if (k == ack_at) ack_r = 1'b1;
      k++;
      req_cycles = k;
    end else begin
      k = 0;
    end
  end

  // Driver: called at a negedge; pushes the expectation right after the accepting edge
  task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic [1:0] exp_exc,
                       input int lat, input bit push, output int waited);
    int p;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_sext  = sext;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    waited = 0;
    #1;
    while (bus.req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("req_ready_wait", bus.req_ready, 1'b1);
    check("stall_on_req", bus.stall, 1'b1);
    @(posedge clk);
    #1;
    p = cyc;
    if (push) begin
      exp_q.push_back({exp_exc, exp_rdata});
      exp_cyc_q.push_back(p + lat - 1);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  int w;

  initial begin
    reset         = 1'b0;
    stray_ack     = 1'b0;
    ack_r         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_sext  = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_stall", bus.stall, 1'b0);
    check("rst_mem_be_we", {bus.mem_be, bus.mem_we}, 5'b0);
    check("rst_state", state_o, 2'd0);
    reset = 1'b1;
    @(negedge clk);

    // lbu 0x1003, ack in third request cycle -> resp four cycles after accept
    rd_word = 32'h80FF1234; ack_at = 2;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_1003, 32'h0, 32'h0000_0080, 2'd0, 4, 1'b1, w);
    drain();
    check("lbu_addr", cap_addr, 32'h0000_1000);
    check("lbu_be", cap_be, 4'b0000);
    check("lbu_we", cap_we, 1'b0);

    // lh 0x2002, zero-wait
    rd_word = 32'h8001FFFF; ack_at = 0;
    issue(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'hFFFF_8001, 2'd0, 2, 1'b1, w);
    drain();
    check("lh_addr", cap_addr, 32'h0000_2000);

    // lhu same word, zero-extended
    issue(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 32'h0000_8001, 2'd0, 2, 1'b1, w);
    drain();

    // sb 0x3001
    ack_at = 1;
    issue(1'b1, 2'd2, 1'b0, 32'h0000_3001, 32'h0000_00AB, 32'h0, 2'd0, 3, 1'b1, w);
    drain();
    check("sb_be", cap_be, 4'b0010);
    check("sb_wdata", cap_wdata, 32'hABAB_ABAB);
    check("sb_we", cap_we, 1'b1);
    check("sb_addr", cap_addr, 32'h0000_3000);

    // sw misaligned: no memory request, response next cycle
    saw_req = 1'b0;
    issue(1'b1, 2'd0, 1'b0, 32'h0000_4002, 32'h1234_5678, 32'h0, 2'd2, 1, 1'b1, w);
    drain();
    check("sw_mis_no_req", saw_req, 1'b0);

    // lh misaligned
    saw_req = 1'b0;
    issue(1'b0, 2'd1, 1'b1, 32'h0000_2001, 32'h0, 32'h0, 2'd1, 1, 1'b1, w);
    drain();
    check("lh_mis_no_req", saw_req, 1'b0);

    // lb 0x6001 sign-extended
    rd_word = 32'h0000_8000; ack_at = 1;
    issue(1'b0, 2'd2, 1'b1, 32'h0000_6001, 32'h0, 32'hFFFF_FF80, 2'd0, 3, 1'b1, w);
    drain();

    // sh 0x7002
    ack_at = 0;
    issue(1'b1, 2'd1, 1'b0, 32'h0000_7002, 32'hCAFE_1234, 32'h0, 2'd0, 2, 1'b1, w);
    drain();
    check("sh_be", cap_be, 4'b1100);
    check("sh_wdata", cap_wdata, 32'h1234_1234);

    // size 3 load behaves as word
    rd_word = 32'hDEAD_BEEF;
    issue(1'b0, 2'd3, 1'b1, 32'h0000_5008, 32'h0, 32'hDEAD_BEEF, 2'd0, 2, 1'b1, w);
    drain();
    check("lw3_addr", cap_addr, 32'h0000_5008);

    // timeout: no ack, mem_req held TMO cycles
    rd_word = 32'h1111_1111; ack_at = -1;
    issue(1'b0, 2'd0, 1'b0, 32'h0000_8000, 32'h0, 32'h0, 2'd3, TMO + 1, 1'b1, w);
    drain();
    check("tmo_req_cycles", req_cycles, TMO);

    // ack in the last allowed cycle wins
    ack_at = TMO - 1;
    issue(1'b0, 2'd0, 1'b0, 32'h0000_8000, 32'h0, 32'h1111_1111, 2'd0, TMO + 1, 1'b1, w);
    drain();
    check("late_ack_req_cycles", req_cycles, TMO);

    // stray ack in IDLE is ignored
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_state", state_o, 2'd0);

    // reset mid-ACCESS abandons the transaction
    ack_at = -1;
    issue(1'b0, 2'd0, 1'b0, 32'h0000_9000, 32'h0, 32'h0, 2'd0, 0, 1'b0, w);
    check("pre_rst_mem_req", bus.mem_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_mem_req", bus.mem_req, 1'b0);
    check("rst_mid_req_ready", bus.req_ready, 1'b1);
    check("rst_mid_resp_valid", bus.resp_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    rd_word = 32'h0BAD_F00D; ack_at = 0;
    issue(1'b0, 2'd0, 1'b0, 32'h0000_A000, 32'h0, 32'h0BAD_F00D, 2'd0, 2, 1'b1, w);
    check("post_rst_first_edge", w, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_A001, 32'h0, 32'h0000_00F0, 2'd0, 2, 1'b1, w);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
